// File: rtl/out_buf_pkg.sv
// Shared types and constants for the decoder output buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package out_buf_pkg;

  // Default payload: 4 px * 3 components * 14 bits.
  localparam int OB_DATA_WIDTH = 168;

  // The SOF tag sits directly above the payload in each RAM word.
  function automatic int ob_sof_pos(input int data_width);
    return data_width;
  endfunction

  // Control half of a skid entry; the payload is appended by the user.
  typedef struct packed {
    logic valid;
    logic sof;
  } skid_ctl_t;

endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears one clk_r edge after re/raddr.
// Backpressure: none; every enabled access completes.
module sync_dp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_w,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clk_r,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_w) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk_r) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/out_fifo_fwft.sv
// First-word-fall-through pixel output FIFO with runtime depth and SOF flush.
// Latency: word written at edge E0 into an empty FIFO is presented after E2.
// Backpressure: none on input (full drops + sticky error); out_valid/out_ready on output at 1 word/clk.
module out_fifo_fwft
  import out_buf_pkg::*;
#(
  parameter int DATA_WIDTH = OB_DATA_WIDTH,
  parameter int MAX_DEPTH  = 1280,
  parameter int ADDR_WIDTH = $clog2(MAX_DEPTH),
  parameter int CNT_WIDTH  = $clog2(MAX_DEPTH + 1),
  parameter int ID         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  fifo_depth,
  input  logic [CNT_WIDTH-1:0]  af_thres,
  input  logic [CNT_WIDTH-1:0]  ae_thres,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  input  logic                  err_clr
);

  localparam int RAM_W   = DATA_WIDTH + 1;
  localparam int SOF_POS = ob_sof_pos(DATA_WIDTH);

  typedef struct packed {
    skid_ctl_t             ctl;
    logic [DATA_WIDTH-1:0] data;
  } skid_t;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  fill_q, fill_d;
  logic                  pend_q, pend_d;
  skid_t                 head_q, head_d, spare_q, spare_d;
  logic                  ovf_q, ovf_d, af_q, af_d, ae_q, ae_d;

  logic                  flush, pop, has_room, wr_acc, drop, rd_issue;
  logic [1:0]            occ;
  logic [CNT_WIDTH-1:0]  unread;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [RAM_W-1:0]      ram_wdata, ram_rdata;
  skid_t                 rd_ent;

  // Wrap exactly at fifo_depth-1 so non-power-of-2 depths work.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p,
                                                    input logic [CNT_WIDTH-1:0]  depth);
    return (CNT_WIDTH'(p) == depth - CNT_WIDTH'(1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Control decode: write acceptance, pop, and prefetch issue.
  // Words already read (skid entries + read in flight) are subtracted from
  // fill_level to find what is still waiting in the RAM. A read is issued only
  // if its data will find a free skid slot when it lands next cycle.
  always_comb begin
    flush    = in_valid & in_sof;
    pop      = head_q.ctl.valid & out_ready;
    has_room = fill_q < fifo_depth;
    wr_acc   = in_valid & ~in_sof & has_room;
    drop     = in_valid & ~in_sof & ~has_room;
    occ      = 2'(head_q.ctl.valid) + 2'(spare_q.ctl.valid) + 2'(pend_q);
    unread   = fill_q - CNT_WIDTH'(occ);
    rd_issue = ~flush & (unread != '0) & ((occ < 2'd2) | ((occ == 2'd2) & pop));
    rd_ent.ctl.valid = 1'b1;
    rd_ent.ctl.sof   = ram_rdata[SOF_POS];
    rd_ent.data      = ram_rdata[DATA_WIDTH-1:0];
  end

  // A SOF word always lands at address 0, restarting both pointers.
  assign ram_we    = flush | wr_acc;
  assign ram_waddr = flush ? '0 : wr_ptr_q;
  assign ram_wdata = {in_sof, in_data};

  sync_dp_ram #(
    .WIDTH (RAM_W),
    .DEPTH (MAX_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk_w (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .clk_r (clk),
    .re    (rd_issue),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Next state: skid shift on pop, landing read data, pointers, count, flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    pend_d   = rd_issue;
    head_d   = head_q;
    spare_d  = spare_q;

    if (pop) begin
      head_d              = spare_q;
      spare_d.ctl.valid   = 1'b0;
    end
    if (pend_q) begin
      if (!head_d.ctl.valid) head_d  = rd_ent;
      else                   spare_d = rd_ent;
    end
    if (rd_issue) rd_ptr_d = ptr_inc(rd_ptr_q, fifo_depth);

    if (flush) begin
      // Old content is abandoned; an in-flight read is simply never consumed.
      wr_ptr_d          = ADDR_WIDTH'(1);
      rd_ptr_d          = '0;
      fill_d            = CNT_WIDTH'(1);
      head_d.ctl.valid  = 1'b0;
      spare_d.ctl.valid = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q, fifo_depth);
      fill_d = fill_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(pop);
    end

    // A drop in the same cycle as err_clr keeps the flag set.
    ovf_d = drop ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    // Flags follow the registered count, hence one edge behind it.
    af_d  = fill_q >= af_thres;
    ae_d  = fill_q <  ae_thres;
  end

  // State registers; reset discards all content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pend_q   <= 1'b0;
      head_q   <= '0;
      spare_q  <= '0;
      ovf_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      pend_q   <= pend_d;
      head_q   <= head_d;
      spare_q  <= spare_d;
      ovf_q    <= ovf_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Configuration sanity check, tagged with the instance number.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (int'(fifo_depth) >= 2 && int'(fifo_depth) <= MAX_DEPTH)
        else $error("out_fifo_fwft[%0d]: fifo_depth %0d out of range", ID, fifo_depth);
    end
  end

  assign out_data     = head_q.data;
  assign out_sof      = head_q.ctl.sof;
  assign out_valid    = head_q.ctl.valid;
  assign fill_level   = fill_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_out_fifo_fwft.sv
// Directed bench for out_fifo_fwft with a queue-based reference model.
// Latency: n/a.
// Backpressure: bench drives out_ready patterns directly.
module tb_out_fifo_fwft;

  localparam int DW = 168;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] fifo_depth, af_thres, ae_thres;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sof, out_ready, err_clr;
  logic [DW-1:0] out_data;
  logic          out_sof, out_valid, almost_full, almost_empty, overflow_err;
  logic [CW-1:0] fill_level;

  out_fifo_fwft dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_depth   (fifo_depth),
    .af_thres     (af_thres),
    .ae_thres     (ae_thres),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fill_level   (fill_level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: words written and not yet popped, each tagged with the
  // edge it was written on. The head is visible two edges after its write.
  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    int            e;
  } ent_t;

  ent_t mq[$];
  ent_t got[$];
  int   cur_edge = 0;
  logic m_ovf = 1'b0, m_af = 1'b0, m_ae = 1'b1;
  logic exp_vld, m_pop, m_full;
  ent_t nw;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_af  = 1'b0;
      m_ae  = 1'b1;
    end
    exp_vld = rst_n && (mq.size() > 0) && (mq[0].e + 2 <= cur_edge);
    chk("m_fill", 256'(fill_level), 256'(mq.size()));
    chk("m_valid", 256'(out_valid), 256'(exp_vld));
    if (exp_vld) begin
      chk("m_data", 256'(out_data), 256'(mq[0].d));
      chk("m_sof", 256'(out_sof), 256'(mq[0].s));
    end
    chk("m_af", 256'(almost_full), 256'(m_af));
    chk("m_ae", 256'(almost_empty), 256'(m_ae));
    chk("m_ovf", 256'(overflow_err), 256'(m_ovf));
    if (rst_n) begin
      m_pop = exp_vld && out_ready;
      m_af  = mq.size() >= int'(af_thres);
      m_ae  = mq.size() <  int'(ae_thres);
      m_full = mq.size() >= int'(fifo_depth);
      if (m_pop) begin
        nw = mq[0];
        nw.e = cur_edge + 1;
        got.push_back(nw);
      end
      nw.d = in_data;
      nw.s = in_sof;
      nw.e = cur_edge + 1;
      if (in_valid && in_sof) begin
        mq.delete();
        mq.push_back(nw);
        if (err_clr) m_ovf = 1'b0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (in_valid && !m_full) mq.push_back(nw);
        if (in_valid && m_full) m_ovf = 1'b1;
        else if (err_clr)       m_ovf = 1'b0;
      end
      cur_edge++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    cyc();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((fill_level != 0) && (n < 40)) begin
      cyc();
      n++;
    end
    chk("drain_done", 256'(fill_level), 256'(0));
    out_ready = 1'b0;
    cyc();
  endtask

  int   wfirst;
  logic seen4, chk_next;

  // Track almost_empty against the moment fill_level first reaches 4.
  task automatic ae_watch();
    if (chk_next) begin
      chk("t5_ae_after", 256'(almost_empty), 256'(0));
      chk_next = 1'b0;
    end
    if (!seen4 && fill_level >= 4) begin
      seen4 = 1'b1;
      chk("t5_fill_is4", 256'(fill_level), 256'(4));
      chk("t5_ae_at4", 256'(almost_empty), 256'(1));
      chk_next = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;  fifo_depth = 8;  af_thres = 6;  ae_thres = 2;
    in_data = '0;  in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_data", 256'(out_data), 256'(0));
    chk("rst_fill", 256'(fill_level), 256'(0));
    chk("rst_ae", 256'(almost_empty), 256'(1));
    chk("rst_af", 256'(almost_full), 256'(0));
    rst_n = 1'b1;
    cyc();

    // 1: fill to depth 8, overflow, clear.
    got.delete();
    for (int i = 0; i < 8; i++) wr(DW'(i), 1'b0);
    chk("t1_fill", 256'(fill_level), 256'(8));
    chk("t1_af", 256'(almost_full), 256'(1));
    wr(DW'(8), 1'b0);
    chk("t1_ovf", 256'(overflow_err), 256'(1));
    chk("t1_fill_hold", 256'(fill_level), 256'(8));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t1_ovf_clr", 256'(overflow_err), 256'(0));
    drain();
    chk("t1_cnt", 256'(got.size()), 256'(8));
    for (int i = 0; i < got.size(); i++) chk("t1_order", 256'(got[i].d), 256'(i));

    // 2: first-word latency.
    got.delete();
    wr(DW'(8'hA5), 1'b0);
    chk("t2_e0_valid", 256'(out_valid), 256'(0));
    cyc();
    chk("t2_e1_valid", 256'(out_valid), 256'(0));
    cyc();
    chk("t2_e2_valid", 256'(out_valid), 256'(1));
    chk("t2_data", 256'(out_data), 256'(8'hA5));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("t2_fill", 256'(fill_level), 256'(0));
    chk("t2_valid_off", 256'(out_valid), 256'(0));

    // 3: depth 5, continuous streaming with wrap.
    fifo_depth = 5;
    cyc();
    got.delete();
    out_ready = 1'b1;
    wfirst = cur_edge + 1;
    for (int i = 0; i < 20; i++) wr(DW'(i), 1'b0);
    drain();
    chk("t3_cnt", 256'(got.size()), 256'(20));
    for (int i = 0; i < got.size(); i++) chk("t3_order", 256'(got[i].d), 256'(i));
    if (got.size() > 0) chk("t3_first_lat", 256'(got[0].e - wfirst), 256'(3));
    for (int i = 1; i < got.size(); i++) chk("t3_gapless", 256'(got[i].e - got[i-1].e), 256'(1));

    // 4: SOF flush with a stalled head.
    fifo_depth = 8;
    cyc();
    got.delete();
    for (int i = 0; i < 6; i++) wr(DW'(8'h10 + i), 1'b0);
    cyc(); cyc(); cyc();
    wr(DW'(1), 1'b1);
    chk("t4_fill", 256'(fill_level), 256'(1));
    chk("t4_valid", 256'(out_valid), 256'(0));
    cyc(); cyc();
    chk("t4_head", 256'(out_data), 256'(1));
    chk("t4_sof", 256'(out_sof), 256'(1));
    drain();
    chk("t4_cnt", 256'(got.size()), 256'(1));
    if (got.size() > 0) chk("t4_only", 256'(got[0].d), 256'(1));

    // 5: toggling ready while writing every cycle.
    fifo_depth = 16;
    ae_thres   = 4;
    af_thres   = 14;
    cyc(); cyc();
    got.delete();
    seen4 = 1'b0;
    chk_next = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_data   = DW'(12'h100 + i);
      out_ready = (i % 2 == 0);
      cyc();
      ae_watch();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    ae_watch();
    chk("t5_seen4", 256'(seen4), 256'(1));
    drain();
    chk("t5_cnt", 256'(got.size()), 256'(12));
    for (int i = 0; i < got.size(); i++) chk("t5_order", 256'(got[i].d), 256'(12'h100 + i));

    // 6: reset mid-operation.
    got.delete();
    for (int i = 0; i < 10; i++) wr(DW'(8'h40 + i), 1'b0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 256'(out_valid), 256'(0));
    chk("t6_fill", 256'(fill_level), 256'(0));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    wr(DW'(16'hBEEF), 1'b0);
    cyc(); cyc();
    chk("t6_post_valid", 256'(out_valid), 256'(1));
    chk("t6_post_data", 256'(out_data), 256'(16'hBEEF));
    drain();
    chk("t6_cnt", 256'(got.size()), 256'(1));
    if (got.size() > 0) chk("t6_word", 256'(got[0].d), 256'(16'hBEEF));

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
